// File: rtl/omem_pkg.sv
// Shared types and sizing for the output-memory sequencer.
package omem_pkg;

  localparam int OMEM_DEPTH = 60;
  localparam int OMEM_AW    = 6;
  localparam int OMEM_DW    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } omem_state_e;

endpackage

// File: rtl/omem_skid.sv
// Two-entry output FIFO holding {addr, data} pairs read back from the bank.
module omem_skid
  import omem_pkg::*;
#(
  parameter int AW = OMEM_AW,
  parameter int DW = OMEM_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    count,
  output logic          head_valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);

  logic [AW+DW-1:0] head_r;
  logic [AW+DW-1:0] tail_r;
  logic [AW+DW-1:0] push_word_s;
  logic [1:0]       count_r;
  logic [1:0]       count_nxt_s;
  logic             valid_r;

  // Next occupancy from the push/pop pair
  always_comb begin
    push_word_s = {push_addr, push_data};
    case ({push, pop})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Slot storage; the head only moves on a pop so it stays stable under stall
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= 2'd0;
      valid_r <= 1'b0;
      head_r  <= {(AW+DW){1'b0}};
      tail_r  <= {(AW+DW){1'b0}};
    end else begin
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != 2'd0);
      if (pop) begin
        if (count_r == 2'd2) begin
          head_r <= tail_r;
          if (push) begin
            tail_r <= push_word_s;
          end
        end else if (push) begin
          head_r <= push_word_s;
        end
      end else if (push) begin
        if (count_r == 2'd0) begin
          head_r <= push_word_s;
        end else begin
          tail_r <= push_word_s;
        end
      end
    end
  end

  assign count      = count_r;
  assign head_valid = valid_r;
  assign head_addr  = head_r[AW+DW-1:DW];
  assign head_data  = head_r[DW-1:0];

endmodule

// File: rtl/omem_ctrl.sv
// Fill/drain sequencer owning the single port of the output memory bank.
module omem_ctrl
  import omem_pkg::*;
#(
  parameter int DEPTH = OMEM_DEPTH,
  parameter int AW    = OMEM_AW,
  parameter int DW    = OMEM_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_bank,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  omem_state_e   state_r;
  logic [AW:0]   wr_count_r;
  logic [AW:0]   rd_ptr_r;
  logic          inflight_r;
  logic [AW-1:0] inflight_addr_r;
  logic          wr_ready_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

  logic          wr_hs_s;
  logic          wr_ok_s;
  logic          wr_bad_s;
  logic          fill_last_s;
  logic          pop_s;
  logic          rd_issue_s;
  logic [2:0]    occ_s;
  logic [1:0]    fifo_count_s;
  logic          fifo_valid_s;
  logic [AW-1:0] fifo_addr_s;
  logic [DW-1:0] fifo_data_s;

  // Handshake decode and read-issue throttle (FIFO + in-flight never exceeds 2)
  always_comb begin
    wr_hs_s     = (state_r == FILL) & wr_valid;
    wr_ok_s     = wr_hs_s & ({1'b0, wr_addr} < DEPTH_C);
    wr_bad_s    = wr_hs_s & ~({1'b0, wr_addr} < DEPTH_C);
    fill_last_s = wr_ok_s & ((wr_count_r + ONE_C) == DEPTH_C);
    pop_s       = fifo_valid_s & out_ready;
    occ_s       = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    rd_issue_s  = (state_r == DRAIN) & (rd_ptr_r < DEPTH_C) & (occ_s < 3'd2);
  end

  // Memory port mux; idle cycles park the address at zero
  always_comb begin
    mem_wr = wr_ok_s;
    mem_rd = rd_issue_s;
    mem_in = wr_data;
    if (wr_ok_s) begin
      mem_bank = wr_addr;
    end else if (rd_issue_s) begin
      mem_bank = rd_ptr_r[AW-1:0];
    end else begin
      mem_bank = {AW{1'b0}};
    end
  end

  // Phase FSM with counters and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= IDLE;
      wr_count_r      <= {(AW+1){1'b0}};
      rd_ptr_r        <= {(AW+1){1'b0}};
      inflight_r      <= 1'b0;
      inflight_addr_r <= {AW{1'b0}};
      wr_ready_r      <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      done_r          <= 1'b0;
      inflight_r      <= rd_issue_s;
      inflight_addr_r <= rd_ptr_r[AW-1:0];
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= FILL;
            wr_count_r <= {(AW+1){1'b0}};
            err_r      <= 1'b0;
            wr_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        FILL: begin
          if (wr_ok_s) begin
            wr_count_r <= wr_count_r + ONE_C;
          end
          if (wr_bad_s) begin
            err_r <= 1'b1;
          end
          if (fill_last_s | flush) begin
            state_r    <= DRAIN;
            rd_ptr_r   <= {(AW+1){1'b0}};
            wr_ready_r <= 1'b0;
          end
        end
        DRAIN: begin
          if (rd_issue_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_C;
          end
          // done is shown for one cycle while still busy, then the FSM idles
          if (done_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (pop_s && (fifo_addr_s == LAST_C)) begin
            done_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          wr_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  omem_skid #(
    .AW(AW),
    .DW(DW)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_r),
    .push_addr (inflight_addr_r),
    .push_data (mem_out),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .head_valid(fifo_valid_s),
    .head_addr (fifo_addr_s),
    .head_data (fifo_data_s)
  );

  assign wr_ready  = wr_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign out_valid = fifo_valid_s;
  assign out_addr  = fifo_addr_s;
  assign out_data  = fifo_data_s;

endmodule

// File: tb/tb_omem_ctrl.sv
// Directed bench for omem_ctrl with a bank model and a drain scoreboard.
module tb_omem_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic       flush;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_addr;
  logic [8:0] wr_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [5:0] out_addr;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] mem_bank;
  logic       mem_wr;
  logic       mem_rd;
  logic [8:0] mem_in;
  logic [8:0] mem_out;

  logic [8:0] bank [0:63];
  logic [8:0] ref_mem [0:63];
  int         errors = 0;
  int         checks = 0;
  bit         rd_allowed = 1'b0;
  bit         fill_on = 1'b0;

  omem_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_bank (mem_bank),
    .mem_wr   (mem_wr),
    .mem_rd   (mem_rd),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bank model: write-through, one-cycle registered read
  always @(posedge clock) begin
    if (mem_wr) bank[mem_bank] <= mem_in;
    if (mem_rd) mem_out <= bank[mem_bank];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    #1;
    chk("excl", 32'(mem_wr & mem_rd), 32'd0);
    if (!rd_allowed) chk("rd_outside_drain", 32'(mem_rd), 32'd0);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input int a, input logic [8:0] d, input logic fl);
    bit exp_wr;
    exp_wr   = fill_on && (a < 60);
    wr_valid = 1'b1;
    wr_addr  = 6'(a);
    wr_data  = d;
    flush    = fl;
    #1;
    chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_bank", 32'(mem_bank), 32'(a));
      chk("mem_in", 32'(mem_in), 32'(d));
      ref_mem[a] = d;
    end else begin
      chk("bank_park", 32'(mem_bank), 32'd0);
    end
    cyc();
    wr_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    fill_on = 1'b1;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_wr_ready", 32'(wr_ready), 32'd1);
    chk("start_err", 32'(err), 32'd0);
  endtask

  task automatic fill_all(input logic [8:0] xv);
    for (int a = 59; a >= 0; a--) begin
      wr(a, 9'(a) ^ xv, 1'b0);
      if (a == 1) chk("fill_59_ready", 32'(wr_ready), 32'd1);
    end
    fill_on = 1'b0;
    chk("fill_done_ready", 32'(wr_ready), 32'd0);
    chk("fill_done_busy", 32'(busy), 32'd1);
  endtask

  task automatic drain(input int stall_addr, input int stall_n, input int rst_addr, input logic exp_err);
    logic [14:0] q[$];
    logic [14:0] e;
    int  n_pop = 0;
    int  n_rd = 0;
    int  c = 0;
    int  st = 0;
    bit  stalled = 1'b0;
    bit  aborted = 1'b0;
    for (int i = 0; i < 60; i++) q.push_back({6'(i), ref_mem[i]});
    rd_allowed = 1'b1;
    while (n_pop < 60 && c < 400 && !aborted) begin
      out_ready = 1'b1;
      if (!stalled && out_valid && out_addr == 6'(stall_addr)) begin
        stalled = 1'b1;
        st = stall_n;
      end
      if (st > 0) begin
        out_ready = 1'b0;
        st--;
        chk("stall_addr", 32'(out_addr), 32'(stall_addr));
        chk("stall_data", 32'(out_data), 32'(q[0][8:0]));
      end
      if (rst_addr >= 0 && out_valid && out_addr == 6'(rst_addr)) begin
        reset = 1'b1;
        out_ready = 1'b0;
        aborted = 1'b1;
      end
      #1;
      if (c < 2) chk("lat_low", 32'(out_valid), 32'd0);
      else if (c == 2) chk("lat_high", 32'(out_valid), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("err_hold", 32'(err), 32'(exp_err));
      chk("excl", 32'(mem_wr & mem_rd), 32'd0);
      if (mem_rd) n_rd++;
      if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("out_addr", 32'(out_addr), 32'(e[14:9]));
        chk("out_data", 32'(out_data), 32'(e[8:0]));
        n_pop++;
      end
      chk("outstanding", 32'((n_rd - n_pop) <= 2), 32'd1);
      @(posedge clock);
      @(negedge clock);
      c++;
    end
    reset = 1'b0;
    if (aborted) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end else begin
      chk("pop_count", 32'(n_pop), 32'd60);
      chk("drain_cycles", 32'(c), 32'(62 + stall_n));
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_err", 32'(err), 32'(exp_err));
      cyc();
      chk("done_clear", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    rd_allowed = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      bank[i]    = 9'h000;
      ref_mem[i] = 9'h000;
    end
    reset = 1'b1; start = 1'b0; flush = 1'b0; wr_valid = 1'b0;
    wr_addr = 6'd0; wr_data = 9'd0; out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // reset state and idle behaviour
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_valid0", 32'(out_valid), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_err0", 32'(err), 32'd0);
    chk("rst_ready0", 32'(wr_ready), 32'd0);
    wr(5, 9'h123, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);

    // full fill, unstalled drain
    do_start();
    fill_all(9'h0A5);
    drain(-1, 0, -1, 1'b0);

    // early flush with write in the flush cycle, then backpressure at 10
    do_start();
    wr(3, 9'h1FF, 1'b0);
    wr(4, 9'h011, 1'b1);
    fill_on = 1'b0;
    chk("flush_ready", 32'(wr_ready), 32'd0);
    drain(10, 5, -1, 1'b0);

    // out-of-range write is dropped, not counted, and flags err
    do_start();
    wr(60, 9'h055, 1'b0);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_ready", 32'(wr_ready), 32'd1);
    fill_all(9'h13C);
    drain(-1, 0, -1, 1'b1);
    chk("err_sticky_idle", 32'(err), 32'd1);
    do_start();
    chk("err_cleared", 32'(err), 32'd0);

    // reset mid-drain, then a clean run from address 0
    fill_all(9'h0F0);
    drain(-1, 0, 30, 1'b0);
    do_start();
    fill_all(9'h1C3);
    drain(-1, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
